// File: rtl/fb_pkg.sv
// Frame-buffer writer shared types and constants.
// Geometry, pixel format and FSM state encoding.
package fb_pkg;

  localparam int PIX_NUM    = 120000;
  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 12;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] data;
  } pix_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// Small synchronous FIFO between the pixel stream and port A.
// Extra pointer bit tells full from empty; flush empties it.
module fb_sync_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic         clk_25mHz,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign dout    = mem[rp[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Read/write pointers; flush drops all entries.
  always_ff @(posedge clk_25mHz or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk_25mHz) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Fills the RGB444 frame buffer from an SOF-tagged pixel stream.
// Raises all_ready once a whole frame has been stored.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int PIX_NUM    = fb_pkg::PIX_NUM,
  parameter int FIFO_DEPTH = fb_pkg::FIFO_DEPTH
) (
  input  logic              clk_25mHz,
  input  logic              rst,
  input  logic              clear,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  output logic              s_ready,
  input  logic              mem_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              all_ready,
  output logic [7:0]        frame_cnt,
  output logic              err_sof
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(PIX_NUM - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  pix_t              f_in;
  pix_t              f_out;
  logic              f_full;
  logic              f_empty;
  logic              push;
  logic              pop;

  assign s_ready = !rst && !f_full && !clear;
  assign push    = s_valid && s_ready;
  assign pop     = !f_empty && !mem_busy && !clear;
  assign f_in    = '{sof: s_sof, data: s_data};

  fb_sync_fifo #(
    .W     ($bits(pix_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_25mHz (clk_25mHz),
    .rst       (rst),
    .flush     (clear),
    .push      (push),
    .pop       (pop),
    .din       (f_in),
    .dout      (f_out),
    .full      (f_full),
    .empty     (f_empty)
  );

  // Frame FSM: place each popped pixel or drop it.
  always_ff @(posedge clk_25mHz or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      all_ready <= 1'b0;
      frame_cnt <= 8'd0;
      err_sof   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      ptr       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      all_ready <= 1'b0;
      err_sof   <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      err_sof <= 1'b0;
      if (pop) begin
        if (f_out.sof) begin
          wr_en   <= 1'b1;
          wr_addr <= '0;
          wr_data <= f_out.data;
          ptr     <= ADDR_W'(1);
          state   <= FILL;
          err_sof <= (state == FILL) &&
                     (ptr != '0);
        end else if (state == FILL) begin
          wr_en   <= 1'b1;
          wr_addr <= ptr;
          wr_data <= f_out.data;
          if (ptr == LAST) begin
            ptr       <= '0;
            all_ready <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed/random bench for fb_pixel_writer.
// Small frame size keeps whole-frame scenarios short.
module tb_fb_pixel_writer;

  localparam int N = 40;

  typedef struct packed {
    logic [18:0] a;
    logic [11:0] d;
    logic        ar;
    logic        err;
  } wr_t;

  logic        clk_25mHz = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        s_valid = 1'b0;
  logic [11:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_ready;
  logic        mem_busy = 1'b0;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        all_ready;
  logic [7:0]  frame_cnt;
  logic        err_sof;

  int tests = 0;
  int fails = 0;
  int stray_err = 0;

  wr_t obs_q[$];
  wr_t exp_q[$];

  int pos = -1;
  bit m_ar = 1'b0;
  int m_frames = 0;

  fb_pixel_writer #(.PIX_NUM(N)) dut (
    .clk_25mHz (clk_25mHz),
    .rst       (rst),
    .clear     (clear),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .s_ready   (s_ready),
    .mem_busy  (mem_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .all_ready (all_ready),
    .frame_cnt (frame_cnt),
    .err_sof   (err_sof)
  );

  always #20 clk_25mHz = ~clk_25mHz;

  always @(negedge clk_25mHz) begin
    if (wr_en)
      obs_q.push_back(wr_t'{wr_addr, wr_data,
                            all_ready, err_sof});
    else if (err_sof)
      stray_err++;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Frame rules: SOF restarts at 0; otherwise
  // pixels land in order only inside a frame.
  task automatic model(input bit sof,
                       input logic [11:0] d);
    if (sof) begin
      exp_q.push_back(wr_t'{19'd0, d, m_ar, pos > 0});
      pos = (N > 1) ? 1 : -1;
    end else if (pos > 0) begin
      if (pos == N - 1) begin
        m_ar = 1'b1;
        m_frames++;
      end
      exp_q.push_back(wr_t'{19'(pos), d, m_ar, 1'b0});
      pos = (pos == N - 1) ? -1 : pos + 1;
    end
  endtask

  task automatic send(input bit sof,
                      input logic [11:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_sof   = sof;
    s_data  = d;
    forever begin
      @(negedge clk_25mHz);
      if (s_ready) break;
      n++;
      if (n > 200) begin
        check("send timeout", 64'(n), 64'd0);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk_25mHz);
    #1;
    s_valid = 1'b0;
    model(sof, d);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin
      @(negedge clk_25mHz);
      #1;
      n++;
    end
    repeat (4) @(negedge clk_25mHz);
    #1;
    check({tag, " count"}, 64'(obs_q.size()),
          64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check(tag, 64'(obs_q.pop_front()),
            64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
    @(posedge clk_25mHz);
    #1;
  endtask

  task automatic frame(input int cnt, input bit sof0);
    for (int i = 0; i < cnt; i++)
      send(sof0 && (i == 0), 12'($urandom));
  endtask

  initial begin
    #5;
    check("rst s_ready", 64'(s_ready), 64'd0);
    check("rst outs",
          64'({wr_en, wr_addr, wr_data, all_ready,
               frame_cnt, err_sof}), 64'd0);
    repeat (3) @(posedge clk_25mHz);
    #1;
    rst = 1'b0;

    // Pixels without SOF are dropped
    frame(5, 1'b0);
    drain("drop");
    check("drop ar", 64'(all_ready), 64'd0);

    // Full frame
    frame(N, 1'b1);
    drain("frame1");
    check("f1 ar", 64'(all_ready), 64'd1);
    check("f1 cnt", 64'(frame_cnt), 64'(m_frames));
    check("f1 cnt1", 64'(frame_cnt), 64'd1);

    // Premature SOF mid-frame, then a full frame
    frame(15, 1'b1);
    frame(N, 1'b1);
    drain("midsof");
    check("mid cnt", 64'(frame_cnt), 64'd2);
    check("mid stray", 64'(stray_err), 64'd0);

    // Port stall while streaming
    mem_busy = 1'b1;
    send(1'b1, 12'($urandom));
    frame(3, 1'b0);
    @(negedge clk_25mHz);
    check("busy s_ready", 64'(s_ready), 64'd0);
    check("busy wr_en", 64'(wr_en), 64'd0);
    repeat (5) @(posedge clk_25mHz);
    #1;
    mem_busy = 1'b0;
    frame(N - 4, 1'b0);
    drain("busy");
    check("busy cnt", 64'(frame_cnt), 64'd3);

    // Clear in DONE
    clear   = 1'b1;
    s_valid = 1'b1;
    s_sof   = 1'b1;
    s_data  = 12'hABC;
    @(negedge clk_25mHz);
    check("clr s_ready", 64'(s_ready), 64'd0);
    @(posedge clk_25mHz);
    #1;
    clear   = 1'b0;
    s_valid = 1'b0;
    pos  = -1;
    m_ar = 1'b0;
    check("clr ar", 64'(all_ready), 64'd0);
    check("clr cnt", 64'(frame_cnt), 64'd3);
    send(1'b0, 12'h555);
    drain("clr drop");

    // Async reset mid-frame
    frame(11, 1'b1);
    drain("prerst");
    #2;
    rst = 1'b1;
    #1;
    check("arst outs",
          64'({wr_en, wr_addr, wr_data, all_ready,
               frame_cnt, err_sof, s_ready}), 64'd0);
    pos = -1;
    m_ar = 1'b0;
    m_frames = 0;
    @(posedge clk_25mHz);
    #1;
    rst = 1'b0;
    frame(N, 1'b1);
    drain("postrst");
    check("post ar", 64'(all_ready), 64'd1);
    check("post cnt", 64'(frame_cnt), 64'd1);
    check("stray err", 64'(stray_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Write-side counterpart of the VGA scan-out block; fills the 12-bit RGB444 frame buffer that VGA scan-out reads by address.
- Accepts a valid/ready pixel stream (LBP result pixels) tagged with start-of-frame. Drives frame-buffer port A (wr_en/wr_addr/wr_data).
- Asserts all_ready once a complete frame is stored, which releases the VGA reader address counter from reset.
- Small input FIFO decouples the stream from frame-buffer port stalls (mem_busy).

Parameters:
- PIX_NUM, 120000, pixels per frame (400x300); last address PIX_NUM-1
- ADDR_W, 19, frame-buffer address width
- DATA_W, 12, pixel width (RGB444)
- FIFO_DEPTH, 4, input FIFO entries, power of 2, >=2

Ports:
- clk_25mHz  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous re-arm pulse
- s_valid  in  1  input pixel valid
- s_data  in  DATA_W  input pixel
- s_sof  in  1  pixel is first of frame (qualified by s_valid)
- s_ready  out  1  input accept
- mem_busy  in  1  frame-buffer port unavailable this cycle
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- all_ready  out  1  full frame stored; held until clear/rst
- frame_cnt  out  8  completed frames, wraps 255->0
- err_sof  out  1  one-cycle pulse on premature SOF

Behaviour:
- Reset (async rst) and clear (sync) values:
  - s_ready=0 during rst.
  - wr_en=0, wr_addr=0, wr_data=0, all_ready=0, err_sof=0.
  - frame_cnt=0 on rst only; clear does not change it.
  - FIFO emptied; state=IDLE; internal address pointer ptr=0.
- clear has priority over every other event in its cycle. A pixel offered in the clear cycle is not accepted (s_ready=0 that cycle).
- Handshake: push when s_valid&&s_ready; s_ready = !fifo_full. There is no full-with-pop pass-through. s_data and s_sof are stored together.
- Pop when FIFO non-empty && !mem_busy. Each pop produces one registered output cycle; a popped pixel is either written or dropped.
- Latency: handshake in cycle k -> wr_en high in cycle k+2 if mem_busy stays low. Sustained throughput is 1 pixel/cycle.
- wr_en is a single-cycle strobe per written pixel. wr_addr and wr_data are valid only while wr_en=1 and hold their last values otherwise.
- State IDLE:
  - Popped pixel with sof=0 is dropped.
  - Popped pixel with sof=1 is written at addr 0; ptr<=1; go to FILL.
- State FILL:
  - Popped pixel with sof=0 is written at ptr; ptr<=ptr+1.
  - Popped pixel with sof=1 and ptr!=0: err_sof pulses, pixel is written at addr 0, ptr<=1, stay in FILL. all_ready is unchanged.
  - Write at ptr==PIX_NUM-1: ptr<=0, all_ready<=1 (visible with that wr_en), frame_cnt+1, go to DONE.
- State DONE:
  - all_ready held high.
  - Popped pixel with sof=0 is dropped.
  - Popped pixel with sof=1 is written at addr 0; go to FILL (refresh). all_ready stays high; tearing is accepted.
- ptr never reaches PIX_NUM, so there is no write past PIX_NUM-1.
- mem_busy mid-frame stalls the pop only. ptr, state and outputs hold; wr_en=0. Upstream sees s_ready drop once the FIFO is full.
- rst mid-frame: all state is lost; the next frame must restart with SOF.

Decomposition:
- Package fb_pkg:
  - PIX_NUM, ADDR_W, DATA_W constants
  - state encoding IDLE/FILL/DONE (2-bit)
  - pixel entry typedef {sof, data}
- Sub-module fb_sync_fifo: sync FIFO, DATA_W+1 wide, depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, flush.
  - flush is driven by clear.
- Top-level contents: FSM, pointer, output registers.

Test Plan:
- rst then 5 pixels, sof=0, s_valid=1 -> no wr_en, all_ready=0, pixels dropped.
- Full frame: sof pixel 0x123 then 119999 increments -> wr_addr 0..119999 in order, wr_data matches, all_ready rises with the addr 119999 write, frame_cnt=1.
- Mid-frame SOF: sof at pixel 500 -> err_sof pulse one cycle, next wr_addr=0, completion needs 120000 more pixels.
- mem_busy=1 for 10 cycles while streaming -> s_ready low after 4 pushes, no lost or duplicated pixels, addresses contiguous.
- clear in DONE -> all_ready=0 next cycle, frame_cnt held, FIFO empty, next non-SOF pixel dropped.
- Async rst asserted mid-FILL -> all outputs 0 immediately; a following SOF frame completes normally with frame_cnt=1.
